// File: rtl/jedro_1_decoder.sv
// RV32I decode stage for the jedro_1 core.
// Handles OP, OP-IMM and LUI; any other encoding is passed downstream flagged
// illegal. Register-file read addresses come straight off the instruction word.
// Decoded fields sit in a single output register offered over valid/ready.
module jedro_1_decoder #(
   parameter int DATA_WIDTH   = 32,
   parameter int ALU_OP_WIDTH = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic [31:0]             instr_i,
   input  logic                    instr_valid_i,
   output logic                    instr_ready_o,
   output logic [4:0]              rs1_addr_o,
   output logic [4:0]              rs2_addr_o,
   input  logic [DATA_WIDTH-1:0]   rs1_data_i,
   input  logic [DATA_WIDTH-1:0]   rs2_data_i,
   output logic [ALU_OP_WIDTH-1:0] alu_op_sel_o,
   output logic [DATA_WIDTH-1:0]   opa_o,
   output logic [DATA_WIDTH-1:0]   opb_o,
   output logic [4:0]              rd_addr_o,
   output logic                    rd_we_o,
   output logic                    illegal_instr_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd;

   logic [ALU_OP_WIDTH-1:0] dec_op;
   logic [DATA_WIDTH-1:0]   dec_opa;
   logic [DATA_WIDTH-1:0]   dec_opb;
   logic                    dec_ill;
   logic                    dec_we;

   logic                    out_valid_q;
   logic                    ill_q;
   logic                    accept;

   assign opcode = instr_i[6:0];
   assign rd     = instr_i[11:7];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   assign rs1_addr_o = instr_i[19:15];
   assign rs2_addr_o = instr_i[24:20];

   // Flush blocks acceptance so a same-cycle instruction is dropped.
   assign instr_ready_o = !flush_i && (!out_valid_q || out_ready_i);
   assign accept        = instr_valid_i && instr_ready_o;

   assign out_valid_o     = out_valid_q;
   assign illegal_instr_o = ill_q && out_valid_q;

   // Combinational decode of the instruction currently on instr_i.
   always_comb begin
      dec_ill = 1'b1;
      dec_op  = '0;
      dec_opa = '0;
      dec_opb = '0;
      case (opcode)
         OPC_OP: begin
            dec_opa = rs1_data_i;
            dec_opb = rs2_data_i;
            dec_op  = ALU_OP_WIDTH'({funct7[5], funct3});
            if (funct7 == F7_ZERO ||
                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
               dec_ill = 1'b0;
         end
         OPC_OP_IMM: begin
            dec_opa = rs1_data_i;
            case (funct3)
               3'b001: begin
                  dec_op  = ALU_OP_WIDTH'(4'b0001);
                  dec_opb = DATA_WIDTH'(instr_i[24:20]);
                  dec_ill = (funct7 != F7_ZERO);
               end
               3'b101: begin
                  dec_op  = ALU_OP_WIDTH'({funct7[5], funct3});
                  dec_opb = DATA_WIDTH'(instr_i[24:20]);
                  dec_ill = !(funct7 == F7_ZERO || funct7 == F7_ALT);
               end
               default: begin
                  // SLTIU compares against the sign-extended immediate too.
                  dec_op  = ALU_OP_WIDTH'({1'b0, funct3});
                  dec_opb = DATA_WIDTH'($signed(instr_i[31:20]));
                  dec_ill = 1'b0;
               end
            endcase
         end
         OPC_LUI: begin
            dec_ill = 1'b0;
            dec_opb = DATA_WIDTH'({instr_i[31:12], 12'b0});
         end
         default: dec_ill = 1'b1;
      endcase
      // Illegal encodings leave the ALU doing a harmless 0 + 0.
      if (dec_ill) begin
         dec_op  = '0;
         dec_opa = '0;
         dec_opb = '0;
      end
   end

   assign dec_we = !dec_ill && (rd != 5'd0);

   // Output pipeline register: flush, load on accept, drain on consume.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q  <= 1'b0;
         alu_op_sel_o <= '0;
         opa_o        <= '0;
         opb_o        <= '0;
         rd_addr_o    <= '0;
         rd_we_o      <= 1'b0;
         ill_q        <= 1'b0;
      end else if (flush_i) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q  <= 1'b1;
         alu_op_sel_o <= dec_op;
         opa_o        <= dec_opa;
         opb_o        <= dec_opb;
         rd_addr_o    <= rd;
         rd_we_o      <= dec_we;
         ill_q        <= dec_ill;
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jedro_1_decoder.sv
// Self-checking bench for jedro_1_decoder with a queue of expected results.
module tb_jedro_1_decoder;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic [31:0] instr_i = '0;
   logic        instr_valid_i = 1'b0;
   logic        instr_ready_o;
   logic [4:0]  rs1_addr_o, rs2_addr_o;
   logic [31:0] rs1_data_i = '0, rs2_data_i = '0;
   logic [3:0]  alu_op_sel_o;
   logic [31:0] opa_o, opb_o;
   logic [4:0]  rd_addr_o;
   logic        rd_we_o, illegal_instr_o, out_valid_o;
   logic        out_ready_i = 1'b1;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] d1, d2;
      logic [4:0]  a1, a2;
      logic [3:0]  op;
      logic [31:0] opa, opb;
      logic [4:0]  rd;
      logic        we, ill;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   vec_t e;
   int   n_cmp = 0;
   int   n_err = 0;

   jedro_1_decoder dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .instr_i(instr_i), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
      .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .alu_op_sel_o(alu_op_sel_o), .opa_o(opa_o), .opb_o(opb_o),
      .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .illegal_instr_o(illegal_instr_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic vec_t mk(logic [31:0] instr, logic [31:0] d1, logic [31:0] d2,
                               logic [4:0] a1, logic [4:0] a2, logic [3:0] op,
                               logic [31:0] opa, logic [31:0] opb, logic [4:0] rd,
                               logic we, logic ill);
      vec_t v;
      v.instr = instr; v.d1 = d1; v.d2 = d2; v.a1 = a1; v.a2 = a2;
      v.op = op; v.opa = opa; v.opb = opb; v.rd = rd; v.we = we; v.ill = ill;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      instr_i    = v.instr;
      rs1_data_i = v.d1;
      rs2_data_i = v.d2;
      instr_valid_i = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({out_valid_o, alu_op_sel_o, opa_o, opb_o, rd_addr_o, rd_we_o, illegal_instr_o} !== '0) begin
         n_err++;
         $display("FAIL reset_initial: outputs not zero, valid=%b op=%h opa=%h", out_valid_o, alu_op_sel_o, opa_o);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      out_ready_i = 1'b0;
      drive(mk(32'h002081B3, 5, 7, 1, 2, 4'h0, 5, 7, 3, 1, 0));
      @(posedge clk_i); #1;
      instr_valid_i = 1'b0;
      n_cmp++;
      if (out_valid_o !== 1'b1) begin
         n_err++;
         $display("FAIL reset_preload: out_valid=%b required 1", out_valid_o);
      end
      #2 rst_i = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid_o, alu_op_sel_o, opa_o, opb_o, rd_addr_o, rd_we_o, illegal_instr_o} !== '0) begin
         n_err++;
         $display("FAIL reset_async: valid=%b opa=%h opb=%h rd=%0d we=%b required all 0",
                  out_valid_o, opa_o, opb_o, rd_addr_o, rd_we_o);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      out_ready_i = 1'b1;
      #1;
      n_cmp++;
      if (instr_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: instr_ready=%b required 1", instr_ready_o);
      end
   endtask

   // Continuous stream with out_ready high: one result per cycle, no bubbles.
   task automatic test_back_to_back();
      vecs.delete();
      vecs.push_back(mk(32'h002081B3, 5, 7, 1, 2, 4'h0, 5, 7, 3, 1, 0));
      vecs.push_back(mk(32'h402081B3, 20, 7, 1, 2, 4'h8, 20, 7, 3, 1, 0));
      vecs.push_back(mk(32'h0020C1B3, 32'hF0F0, 32'h0FF0, 1, 2, 4'h4, 32'hF0F0, 32'h0FF0, 3, 1, 0));
      vecs.push_back(mk(32'hFFF00293, 0, 9, 0, 31, 4'h0, 0, 32'hFFFFFFFF, 5, 1, 0));
      vecs.push_back(mk(32'hFFF0B193, 3, 0, 1, 31, 4'h3, 3, 32'hFFFFFFFF, 3, 1, 0));
      vecs.push_back(mk(32'h40435313, 32'h80000000, 1, 6, 4, 4'hD, 32'h80000000, 4, 6, 1, 0));
      vecs.push_back(mk(32'h123453B7, 32'hDEAD, 32'hBEEF, 8, 3, 4'h0, 0, 32'h12345000, 7, 1, 0));
      vecs.push_back(mk(32'h00000000, 11, 12, 0, 0, 4'h0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(32'h022081B3, 5, 7, 1, 2, 4'h0, 0, 0, 3, 0, 1));
      vecs.push_back(mk(32'h40209193, 5, 7, 1, 2, 4'h0, 0, 0, 3, 0, 1));
      vecs.push_back(mk(32'h00208033, 5, 7, 1, 2, 4'h0, 5, 7, 0, 0, 0));
      foreach (vecs[i]) begin
         drive(vecs[i]);
         #1;
         n_cmp++;
         if (rs1_addr_o !== vecs[i].a1 || rs2_addr_o !== vecs[i].a2 || instr_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL addr_%0d: rs1=%0d rs2=%0d rdy=%b required rs1=%0d rs2=%0d rdy=1",
                     i, rs1_addr_o, rs2_addr_o, instr_ready_o, vecs[i].a1, vecs[i].a2);
         end
         sb.push_back(vecs[i]);
         @(posedge clk_i); #1;
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty_%0d: queue empty, required 1 entry", i);
         end else begin
            e = sb.pop_front();
            if (out_valid_o !== 1'b1 || alu_op_sel_o !== e.op || opa_o !== e.opa ||
                opb_o !== e.opb || rd_we_o !== e.we || illegal_instr_o !== e.ill ||
                (!e.ill && rd_addr_o !== e.rd)) begin
               n_err++;
               $display("FAIL decode_%08h: v=%b op=%h opa=%h opb=%h rd=%0d we=%b ill=%b required v=1 op=%h opa=%h opb=%h rd=%0d we=%b ill=%b",
                        e.instr, out_valid_o, alu_op_sel_o, opa_o, opb_o, rd_addr_o, rd_we_o,
                        illegal_instr_o, e.op, e.opa, e.opb, e.rd, e.we, e.ill);
            end
         end
      end
      instr_valid_i = 1'b0;
      @(posedge clk_i); #1;
      n_cmp++;
      if (out_valid_o !== 1'b0 || illegal_instr_o !== 1'b0) begin
         n_err++;
         $display("FAIL drain: valid=%b ill=%b required 0 0", out_valid_o, illegal_instr_o);
      end
   endtask

   task automatic test_stall();
      out_ready_i = 1'b1;
      e = mk(32'h002081B3, 5, 7, 1, 2, 4'h0, 5, 7, 3, 1, 0);
      drive(e);
      sb.push_back(e);
      @(posedge clk_i); #1;
      out_ready_i = 1'b0;
      drive(mk(32'h402081B3, 20, 9, 1, 2, 4'h8, 20, 9, 3, 1, 0));
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if (instr_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_ready_%0d: instr_ready=%b required 0", c, instr_ready_o);
         end
         @(posedge clk_i); #1;
         n_cmp++;
         if (out_valid_o !== 1'b1 || alu_op_sel_o !== sb[0].op || opa_o !== sb[0].opa ||
             opb_o !== sb[0].opb || rd_addr_o !== sb[0].rd) begin
            n_err++;
            $display("FAIL stall_hold_%0d: v=%b op=%h opa=%h opb=%h rd=%0d required v=1 op=%h opa=%h opb=%h rd=%0d",
                     c, out_valid_o, alu_op_sel_o, opa_o, opb_o, rd_addr_o,
                     sb[0].op, sb[0].opa, sb[0].opb, sb[0].rd);
         end
      end
      out_ready_i = 1'b1;
      #1;
      n_cmp++;
      if (instr_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL stall_release: instr_ready=%b required 1", instr_ready_o);
      end
      sb.push_back(mk(32'h402081B3, 20, 9, 1, 2, 4'h8, 20, 9, 3, 1, 0));
      @(posedge clk_i); #1;
      void'(sb.pop_front());
      instr_valid_i = 1'b0;
      n_cmp++;
      if (out_valid_o !== 1'b1 || alu_op_sel_o !== sb[0].op || opa_o !== sb[0].opa || opb_o !== sb[0].opb) begin
         n_err++;
         $display("FAIL stall_nobubble: v=%b op=%h opa=%h opb=%h required v=1 op=%h opa=%h opb=%h",
                  out_valid_o, alu_op_sel_o, opa_o, opb_o, sb[0].op, sb[0].opa, sb[0].opb);
      end
      @(posedge clk_i); #1;
      void'(sb.pop_front());
      n_cmp++;
      if (out_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL stall_drain: valid=%b required 0", out_valid_o);
      end
   endtask

   task automatic test_flush();
      out_ready_i = 1'b0;
      e = mk(32'h002081B3, 5, 7, 1, 2, 4'h0, 5, 7, 3, 1, 0);
      drive(e);
      sb.push_back(e);
      @(posedge clk_i); #1;
      flush_i = 1'b1;
      out_ready_i = 1'b1;
      drive(mk(32'h123453B7, 0, 0, 8, 3, 4'h0, 0, 32'h12345000, 7, 1, 0));
      #1;
      n_cmp++;
      if (instr_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_ready: instr_ready=%b required 0", instr_ready_o);
      end
      @(posedge clk_i); #1;
      void'(sb.pop_front());
      flush_i = 1'b0;
      instr_valid_i = 1'b0;
      n_cmp++;
      if (out_valid_o !== 1'b0 || illegal_instr_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_clear: valid=%b ill=%b required 0 0", out_valid_o, illegal_instr_o);
      end
      @(posedge clk_i); #1;
      n_cmp++;
      if (out_valid_o !== 1'b0 || sb.size() != 0) begin
         n_err++;
         $display("FAIL flush_dropped: valid=%b pending=%0d required 0 0", out_valid_o, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_flush();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
